// File: rtl/decoder_2x4_pkg.sv
// Shared select-width constants and one-hot decode helper for select fan-out blocks.
package decoder_2x4_pkg;

  localparam int unsigned SEL_W = 2;
  localparam int unsigned OUT_W = 1 << SEL_W;

  function automatic logic [OUT_W-1:0] onehot4(logic [SEL_W-1:0] sel);
    logic [OUT_W-1:0] res;
    res = '0;
    res[sel] = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/decoder_2x4.sv
// Registered 2-to-4 one-hot decoder with enable; y is all-zero or exactly one-hot.
module decoder_2x4
  import decoder_2x4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEL_W-1:0] a,
  output logic [OUT_W-1:0] y
);

  logic [OUT_W-1:0] y_d, y_q;

  always_comb begin
    y_d = '0;
    if (en) begin
      y_d = onehot4(a);
    end
  end

  // Reset is synchronous and overrides the decode on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_decoder_2x4.sv
// Directed and random checks of decoder_2x4 against a queued one-cycle-delayed reference.
module tb_decoder_2x4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] a;
  logic [3:0] y;

  int checks;
  int errors;
  logic [3:0] exp_q[$];

  decoder_2x4 u_dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .a   (a),
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ref_decode(logic r, logic e, logic [1:0] s);
    logic [3:0] v;
    if (r || !e) begin
      v = 4'b0000;
    end else begin
      case (s)
        2'd0:    v = 4'b0001;
        2'd1:    v = 4'b0010;
        2'd2:    v = 4'b0100;
        default: v = 4'b1000;
      endcase
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic check_onehot(input string tag);
    logic ok;
    ok = ($countones(y) <= 1) && !$isunknown(y);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s onehot_or_zero observed=%b expected=<=1 bit set", tag, y);
    end
  endtask

  // Drive inputs, queue the expected output, clock once, then pop and compare.
  task automatic step(input string tag, input logic r, input logic e, input logic [1:0] s);
    logic [3:0] exp_v;
    rst = r;
    en  = e;
    a   = s;
    exp_q.push_back(ref_decode(r, e, s));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard observed=empty expected=entry", tag);
    end else begin
      exp_v = exp_q.pop_front();
      check(tag, y, exp_v);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    en  = 1'b1;
    a   = 2'b11;

    // Reset held for two edges with an active decode request on the inputs.
    step("reset_edge0", 1'b1, 1'b1, 2'b11);
    step("reset_edge1", 1'b1, 1'b1, 2'b11);
    step("reset_release", 1'b0, 1'b1, 2'b11);
    check_onehot("after_release");

    // Full sweep with enable.
    step("sweep_a0", 1'b0, 1'b1, 2'b00);
    step("sweep_a1", 1'b0, 1'b1, 2'b01);
    step("sweep_a2", 1'b0, 1'b1, 2'b10);
    step("sweep_a3", 1'b0, 1'b1, 2'b11);

    // Disable, then re-enable with a held.
    step("disable_a1", 1'b0, 1'b0, 2'b01);
    step("reenable_a1", 1'b0, 1'b1, 2'b01);

    // Reset must win over a simultaneous decode request.
    step("pre_prio_a2", 1'b0, 1'b1, 2'b10);
    step("reset_priority", 1'b1, 1'b1, 2'b11);

    // Mid-cycle glitch on a must not reach y.
    step("glitch_setup", 1'b0, 1'b1, 2'b00);
    exp_q.push_back(ref_decode(1'b0, 1'b1, 2'b00));
    #1 a = 2'b11;
    #2 check("glitch_mid_a3", y, 4'b0001);
    #1 a = 2'b00;
    #1 check("glitch_mid_a0", y, 4'b0001);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL glitch_edge scoreboard observed=empty expected=entry");
    end else begin
      check("glitch_edge", y, exp_q.pop_front());
    end

    // Random cycles with invariant and reference comparison each cycle.
    for (int i = 0; i < 200; i++) begin
      logic       r_r;
      logic       r_e;
      logic [1:0] r_a;
      r_r = ($urandom_range(0, 7) == 0);
      r_e = ($urandom_range(0, 3) != 0);
      r_a = 2'($urandom_range(0, 3));
      step("random", r_r, r_e, r_a);
      check_onehot("random_inv");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
